// File: rtl/scaler_pkg.sv
// -----------------------------------------------------------------------------
// scaler_pkg
// Shared definitions for the horizontal scaler control path.
//   - ctrl_state_e     : controller state encoding. Bit 1 = running, bit 0 = pending.
//   - SCALER_STEP_ONE  : fixed-point 1.000 step (4096).
//   - SCALER_STEP_MIN  : default smallest accepted step (0.25).
//   - SCALER_STEP_MAX  : default largest accepted step (8.0).
//   - step_in_range()  : inclusive range check used on incoming requests.
// -----------------------------------------------------------------------------
package scaler_pkg;

    localparam int unsigned SCALER_STEP_W   = 16;
    localparam int unsigned SCALER_STAT_W   = 16;
    localparam int unsigned SCALER_STEP_ONE = 4096;
    localparam int unsigned SCALER_STEP_MIN = 1024;
    localparam int unsigned SCALER_STEP_MAX = 32768;

    // The encoding is chosen so that running = state[1] and pending = state[0].
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ARMED    = 2'b01,
        ST_RUN      = 2'b10,
        ST_RUN_PEND = 2'b11
    } ctrl_state_e;

    function automatic logic step_in_range(
        input logic [SCALER_STEP_W-1:0] step,
        input logic [SCALER_STEP_W-1:0] lo,
        input logic [SCALER_STEP_W-1:0] hi
    );
        return (step >= lo) && (step <= hi);
    endfunction

    function automatic logic state_running(input ctrl_state_e s);
        return (s == ST_RUN) || (s == ST_RUN_PEND);
    endfunction

    function automatic logic state_pending(input ctrl_state_e s);
        return (s == ST_ARMED) || (s == ST_RUN_PEND);
    endfunction

endpackage

// File: rtl/scaler_ctrl_stat.sv
// -----------------------------------------------------------------------------
// scaler_ctrl_stat
// Line/frame geometry statistics for the scaler controller.
//   A pixel counter counts data-enable beats and restarts on every line start;
//   a line counter counts line starts and restarts on every frame start.
//   Both saturate at all-ones. On a line start the finished line's pixel count
//   is captured; on a frame start the finished frame's line count is captured.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_de                : input data enable
//   i_ls                : line-start event (de & hs)
//   i_fs                : frame-start event (de & vs)
//   o_width             : pixels in the previous line
//   o_height            : lines in the previous frame
// -----------------------------------------------------------------------------
module scaler_ctrl_stat
    import scaler_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_de,
    input  logic                     i_ls,
    input  logic                     i_fs,
    output logic [SCALER_STAT_W-1:0] o_width,
    output logic [SCALER_STAT_W-1:0] o_height
);

    localparam logic [SCALER_STAT_W-1:0] LP_SAT = '1;
    localparam logic [SCALER_STAT_W-1:0] LP_ONE = SCALER_STAT_W'(1);

    logic [SCALER_STAT_W-1:0] r_pix_cnt;
    logic [SCALER_STAT_W-1:0] r_line_cnt;
    logic [SCALER_STAT_W-1:0] r_width;
    logic [SCALER_STAT_W-1:0] r_height;

    // The start beat itself belongs to the new line/frame, so the counter
    // restarts at 1 rather than 0; a 64-pixel line then reports 64.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt <= '0;
            r_width   <= '0;
        end else if (i_ls) begin
            r_width   <= r_pix_cnt;
            r_pix_cnt <= LP_ONE;
        end else if (i_de && (r_pix_cnt != LP_SAT)) begin
            r_pix_cnt <= r_pix_cnt + LP_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_cnt <= '0;
            r_height   <= '0;
        end else if (i_fs) begin
            r_height   <= r_line_cnt;
            r_line_cnt <= i_ls ? LP_ONE : '0;
        end else if (i_ls && (r_line_cnt != LP_SAT)) begin
            r_line_cnt <= r_line_cnt + LP_ONE;
        end
    end

    assign o_width  = r_width;
    assign o_height = r_height;

endmodule

// File: rtl/scaler_h_ctrl.sv
// -----------------------------------------------------------------------------
// scaler_h_ctrl
// Sequencing/configuration controller in front of scaler_h. Takes new step
// values over a valid/ready handshake, range-checks them into a shadow
// register, and applies the shadow value only on a frame start so a frame is
// never scaled with two steps. Video is blocked until a step has been applied.
//
// Optional build macro: SCALER_CTRL_STAT_EN (adds line/frame geometry counters;
// without it stat_width/stat_height are tied to 0).
//
// Handshake: a request transfers on a rising clk edge where cfg_valid and
// cfg_ready are both 1. cfg_ready depends only on the state (1 in IDLE and
// RUN); cfg_valid may stay high while cfg_ready is 0 and nothing transfers.
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cfg_step/cfg_valid         : step request (unsigned fixed-point)
//   cfg_ready                  : request can be taken this cycle
//   cfg_err                    : one-cycle pulse after a rejected request
//   di_i/de_i/hs_i/vs_i        : input video (hs/vs qualified by de)
//   di_o/de_o/hs_o/vs_o        : registered, gated video to the scaler
//   scale_step                 : active step to the scaler
//   running / pending          : video passing / shadow update waiting
//   stat_width / stat_height   : pixels per line / lines per frame
// -----------------------------------------------------------------------------
module scaler_h_ctrl
    import scaler_pkg::*;
#(
    parameter int unsigned PIXEL_STEP  = SCALER_STEP_ONE,
    parameter int unsigned PIXEL_WIDTH = 12,
    parameter int unsigned STEP_MIN    = SCALER_STEP_MIN,
    parameter int unsigned STEP_MAX    = SCALER_STEP_MAX
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SCALER_STEP_W-1:0] cfg_step,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    output logic                     cfg_err,
    input  logic [PIXEL_WIDTH-1:0]   di_i,
    input  logic                     de_i,
    input  logic                     hs_i,
    input  logic                     vs_i,
    output logic [PIXEL_WIDTH-1:0]   di_o,
    output logic                     de_o,
    output logic                     hs_o,
    output logic                     vs_o,
    output logic [SCALER_STEP_W-1:0] scale_step,
    output logic                     running,
    output logic                     pending,
    output logic [SCALER_STAT_W-1:0] stat_width,
    output logic [SCALER_STAT_W-1:0] stat_height
);

    localparam logic [SCALER_STEP_W-1:0] LP_STEP_ONE = PIXEL_STEP[SCALER_STEP_W-1:0];
    localparam logic [SCALER_STEP_W-1:0] LP_STEP_MIN = STEP_MIN[SCALER_STEP_W-1:0];
    localparam logic [SCALER_STEP_W-1:0] LP_STEP_MAX = STEP_MAX[SCALER_STEP_W-1:0];

    // ------------------------------------------------------------------
    // Events and handshake
    // ------------------------------------------------------------------
    logic w_fs;
    logic w_ls;
    logic w_xfer;
    logic w_in_range;
    logic w_accept;
    logic w_reject;

    ctrl_state_e r_state;
    ctrl_state_e w_state_nxt;
    logic        w_apply;

    assign w_fs       = de_i & vs_i;
    assign w_ls       = de_i & hs_i;
    assign cfg_ready  = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_xfer     = cfg_valid & cfg_ready;
    assign w_in_range = step_in_range(cfg_step, LP_STEP_MIN, LP_STEP_MAX);
    assign w_accept   = w_xfer & w_in_range;
    assign w_reject   = w_xfer & ~w_in_range;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A request accepted on the same beat as fs in RUN moves to RUN_PEND
    // without applying: the frame starting on this beat keeps the old step.
    always_comb begin
        w_state_nxt = r_state;
        w_apply     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_fs) begin
                    w_state_nxt = ST_RUN;
                    w_apply     = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN_PEND;
                end
            end
            ST_RUN_PEND: begin
                if (w_fs) begin
                    w_state_nxt = ST_RUN;
                    w_apply     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow / active step and error pulse
    // ------------------------------------------------------------------
    logic [SCALER_STEP_W-1:0] r_shadow;
    logic [SCALER_STEP_W-1:0] r_scale_step;
    logic                     r_cfg_err;

    // Accepts only happen in IDLE/RUN and applies only in ARMED/RUN_PEND,
    // so the shadow is never written and read for an apply on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow     <= LP_STEP_ONE;
            r_scale_step <= LP_STEP_ONE;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= w_reject;
            if (w_accept) begin
                r_shadow <= cfg_step;
            end
            if (w_apply) begin
                r_scale_step <= r_shadow;
            end
        end
    end

    // ------------------------------------------------------------------
    // Video path: one register stage, flags gated by the next state so the
    // fs beat that starts RUN is the first one to pass.
    // ------------------------------------------------------------------
    logic                   w_pass;
    logic [PIXEL_WIDTH-1:0] r_di_o;
    logic                   r_de_o;
    logic                   r_hs_o;
    logic                   r_vs_o;

    assign w_pass = state_running(w_state_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_di_o <= '0;
            r_de_o <= 1'b0;
            r_hs_o <= 1'b0;
            r_vs_o <= 1'b0;
        end else begin
            r_di_o <= di_i;
            r_de_o <= de_i & w_pass;
            r_hs_o <= hs_i & w_pass;
            r_vs_o <= vs_i & w_pass;
        end
    end

    assign di_o       = r_di_o;
    assign de_o       = r_de_o;
    assign hs_o       = r_hs_o;
    assign vs_o       = r_vs_o;
    assign scale_step = r_scale_step;
    assign cfg_err    = r_cfg_err;
    assign running    = state_running(r_state);
    assign pending    = state_pending(r_state);

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef SCALER_CTRL_STAT_EN
    scaler_ctrl_stat u_stat (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_de     (de_i),
        .i_ls     (w_ls),
        .i_fs     (w_fs),
        .o_width  (stat_width),
        .o_height (stat_height)
    );
`else
    // Line starts only feed the statistics block.
    logic w_ls_unused;
    assign w_ls_unused = w_ls;
    assign stat_width  = '0;
    assign stat_height = '0;
`endif

endmodule
